xbar_weight_programmer: RTL and testbench
=========================================

# xbar_weight_programmer

Write-verify programming controller for the 64x64 1T1R memristor crossbar. Accepts one weight-write request at a time and selects the target cell. It then loops: read the cell's conductance level, compare it with the target, and apply a SET or RESET pulse, until the level matches or a pulse budget is exhausted. It is the write side of the array, complementing the inference read path. It reports a status per request.

## Interface
Parameters:
- N_ROWS, 64, crossbar rows
- N_COLS, 64, crossbar columns
- LEVEL_W, 4, conductance level width
- TOL, 0, allowed |level − target| for success
- PULSE_CYC, 8, cycles pulse_en is held per pulse
- SETTLE_CYC, 4, idle cycles after each pulse before re-read
- MAX_PULSES, 16, pulse budget per request
- RD_TIMEOUT, 32, cycles to wait for rd_valid

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_row  in  $clog2(N_ROWS)  target row
- req_col  in  $clog2(N_COLS)  target column
- req_level  in  LEVEL_W  target conductance level
- req_sign  in  1  weight sign, driven to wctl_sign
- abort  in  1  synchronous abort of current request
- sel_row, sel_col  out  as req_row/req_col  latched cell address
- wctl_sign  out  1  latched sign
- pulse_en  out  1  programming pulse active
- pulse_pol  out  1  1 = SET (raise level), 0 = RESET (lower level)
- rd_req  out  1  one-cycle verify-read strobe
- rd_valid  in  1  read result valid
- rd_level  in  LEVEL_W  measured level
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  response consumed
- resp_status  out  2  00 ok, 01 budget exhausted, 10 read timeout, 11 aborted
- resp_pulses  out  $clog2(MAX_PULSES+1)  pulses applied

## Operation
- States: IDLE, READ, WAIT_RD, COMPARE, PULSE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid, latch row/col/level/sign, clear pulse count, go to READ.
- READ: rd_req=1 for exactly one cycle, load the timeout timer, go to WAIT_RD. rd_valid is ignored in READ.
- WAIT_RD:
  - On rd_valid, capture rd_level and go to COMPARE.
  - On timer expiry (RD_TIMEOUT cycles with no rd_valid), go to RESP with status 10.
- COMPARE: diff = |level − target|, computed LEVEL_W+1 bits wide, unsigned-safe.
  - diff ≤ TOL: RESP, status 00.
  - Otherwise, pulse count == MAX_PULSES: RESP, status 01.
  - Otherwise: pulse_pol = (level < target), increment the count, go to PULSE.
- PULSE: pulse_en=1 for exactly PULSE_CYC cycles; pulse_pol stays stable for the whole pulse. Then go to SETTLE.
- SETTLE: SETTLE_CYC cycles with all strobes low, then READ.
- RESP: resp_valid=1, with status and count stable. On resp_ready, go to IDLE.
- abort in READ, WAIT_RD, COMPARE, PULSE or SETTLE:
  - Next state is RESP, status 11.
  - pulse_en is low from the next cycle.
  - Abort beats a simultaneous rd_valid or timer expiry.
  - Abort is ignored in IDLE and RESP.
- sel_row, sel_col and wctl_sign hold their values from acceptance until the next acceptance.

## Timing
- All outputs are registered. req_ready and resp_valid are decoded from registered state.
- Reset values: state IDLE, req_ready=1, pulse_en=0, pulse_pol=0, rd_req=0, resp_valid=0, resp_status=00, resp_pulses=0, sel_row=0, sel_col=0, wctl_sign=0.
- Reset asserted mid-pulse drops pulse_en asynchronously. The in-flight request is discarded with no response.
- Zero-pulse latency, with the request accepted at edge T:
  - rd_req high in cycle T+1.
  - rd_valid earliest in cycle T+2.
  - COMPARE in T+3.
  - resp_valid from T+4.
- Each additional pulse adds 1 (COMPARE) + PULSE_CYC + SETTLE_CYC + 1 (READ) + read wait.
- A new request can be accepted no earlier than the cycle after the resp handshake.

## Structure
- Package xbar_prog_pkg holds:
  - the state enum;
  - the status enum (ST_OK, ST_BUDGET, ST_TIMEOUT, ST_ABORT);
  - the constants POL_SET=1 and POL_RESET=0.
- Sub-module prog_timer: a loadable down-counter with a done flag, reused for the pulse, settle and read-timeout intervals. Width is $clog2 of the largest interval, plus 1.

## Test plan
- Immediate match: target 5, rd_level=5 on the first read → resp_status=00, resp_pulses=0, no pulse_en, resp_valid at T+4.
- Converge up: target 7, model returns 4, 5, 6, 7 → three SET pulses, each exactly 8 cycles, status 00, pulses=3.
- Converge down with TOL=1: target 2, model returns 9, then decrements per pulse → stops at level 3, status 00, pulses=6.
- Budget exhausted: model stuck at 0, target 15 → 16 SET pulses, status 01, pulses=16.
- Read timeout: rd_valid never asserted → resp_valid after 32 WAIT_RD cycles, status 10, pulses=0.
- Abort and reset:
  - abort in the 3rd PULSE cycle → pulse_en low next cycle, status 11.
  - rst_n low mid-SETTLE → all outputs at reset values immediately, req_ready=1 after release.

Source files
------------

// File: rtl/xbar_prog_pkg.sv
// Shared state, status and polarity definitions for the crossbar
// write-verify programmer.
package xbar_prog_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT_RD,
      S_COMPARE,
      S_PULSE,
      S_SETTLE,
      S_RESP
   } prog_state_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_BUDGET  = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_ABORT   = 2'b11
   } prog_status_e;

   localparam logic POL_SET   = 1'b1;
   localparam logic POL_RESET = 1'b0;

endpackage

// File: rtl/xbar_weight_programmer_timer.sv
// Loadable down-counter shared by the pulse, settle and read-timeout
// intervals; done is high whenever the count has reached zero.
module prog_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // A load always wins; otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/xbar_weight_programmer.sv
// Write-verify programming controller for the 1T1R memristor crossbar:
// read, compare, pulse SET/RESET until the cell level matches or budget runs out.
module xbar_weight_programmer
   import xbar_prog_pkg::*;
#(
   parameter int N_ROWS     = 64,
   parameter int N_COLS     = 64,
   parameter int LEVEL_W    = 4,
   parameter int TOL        = 0,
   parameter int PULSE_CYC  = 8,
   parameter int SETTLE_CYC = 4,
   parameter int MAX_PULSES = 16,
   parameter int RD_TIMEOUT = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [$clog2(N_ROWS)-1:0]         req_row,
   input  logic [$clog2(N_COLS)-1:0]         req_col,
   input  logic [LEVEL_W-1:0]                req_level,
   input  logic                              req_sign,
   input  logic                              abort,
   output logic [$clog2(N_ROWS)-1:0]         sel_row,
   output logic [$clog2(N_COLS)-1:0]         sel_col,
   output logic                              wctl_sign,
   output logic                              pulse_en,
   output logic                              pulse_pol,
   output logic                              rd_req,
   input  logic                              rd_valid,
   input  logic [LEVEL_W-1:0]                rd_level,
   output logic                              resp_valid,
   input  logic                              resp_ready,
   output logic [1:0]                        resp_status,
   output logic [$clog2(MAX_PULSES+1)-1:0]   resp_pulses
);

   localparam int ROW_W   = $clog2(N_ROWS);
   localparam int COL_W   = $clog2(N_COLS);
   localparam int CNT_W   = $clog2(MAX_PULSES + 1);
   localparam int DIFF_W  = LEVEL_W + 1;
   localparam int MAX_IVL = (PULSE_CYC > SETTLE_CYC)
                            ? ((PULSE_CYC > RD_TIMEOUT) ? PULSE_CYC : RD_TIMEOUT)
                            : ((SETTLE_CYC > RD_TIMEOUT) ? SETTLE_CYC : RD_TIMEOUT);
   localparam int TMR_W   = $clog2(MAX_IVL) + 1;

   localparam logic [CNT_W-1:0]  MAX_P   = CNT_W'(MAX_PULSES);
   localparam logic [DIFF_W-1:0] TOL_V   = DIFF_W'(TOL);
   localparam logic [TMR_W-1:0]  LD_PUL  = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0]  LD_SET  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]  LD_RDTO = TMR_W'(RD_TIMEOUT - 1);

   prog_state_e        state_q, state_d;
   prog_status_e       status_q, status_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               sign_q, sign_d;
   logic [LEVEL_W-1:0] target_q, target_d;
   logic [LEVEL_W-1:0] meas_q, meas_d;
   logic [CNT_W-1:0]   pulses_q, pulses_d;
   logic [CNT_W-1:0]   respPulses_q, respPulses_d;
   logic               pol_q, pol_d;
   logic               pulseEn_q, pulseEn_d;
   logic               rdReq_q, rdReq_d;

   logic               tmrLoad;
   logic [TMR_W-1:0]   tmrLoadVal;
   logic               tmrDone;
   logic [DIFF_W-1:0]  diff;

   // Widen by one bit so the subtraction never wraps whichever side is larger.
   assign diff = (meas_q >= target_q)
                 ? ({1'b0, meas_q} - {1'b0, target_q})
                 : ({1'b0, target_q} - {1'b0, meas_q});

   prog_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmrLoad),
      .load_val_i (tmrLoadVal),
      .done_o     (tmrDone)
   );

   // Next-state and registered-output decode; outputs are computed from the
   // next state so they line up with the state register on the same edge.
   always_comb begin
      state_d      = state_q;
      status_d     = status_q;
      row_d        = row_q;
      col_d        = col_q;
      sign_d       = sign_q;
      target_d     = target_q;
      meas_d       = meas_q;
      pulses_d     = pulses_q;
      respPulses_d = respPulses_q;
      pol_d        = pol_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               row_d    = req_row;
               col_d    = req_col;
               sign_d   = req_sign;
               target_d = req_level;
               pulses_d = '0;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            state_d = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (rd_valid) begin
               meas_d  = rd_level;
               state_d = S_COMPARE;
            end else if (tmrDone) begin
               status_d = ST_TIMEOUT;
               state_d  = S_RESP;
            end
         end
         S_COMPARE: begin
            if (diff <= TOL_V) begin
               status_d = ST_OK;
               state_d  = S_RESP;
            end else if (pulses_q == MAX_P) begin
               status_d = ST_BUDGET;
               state_d  = S_RESP;
            end else begin
               pol_d    = (meas_q < target_q) ? POL_SET : POL_RESET;
               pulses_d = pulses_q + 1'b1;
               state_d  = S_PULSE;
            end
         end
         S_PULSE: begin
            if (tmrDone) begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmrDone) begin
               state_d = S_READ;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides whatever the active state decided, including a pulse
      // that COMPARE was about to start, so that pulse is never counted.
      if (abort && (state_q != S_IDLE) && (state_q != S_RESP)) begin
         state_d  = S_RESP;
         status_d = ST_ABORT;
         pulses_d = pulses_q;
         pol_d    = pol_q;
         meas_d   = meas_q;
      end

      if ((state_d == S_RESP) && (state_q != S_RESP)) begin
         respPulses_d = pulses_d;
      end

      pulseEn_d = (state_d == S_PULSE);
      rdReq_d   = (state_d == S_READ);

      tmrLoad    = (state_d != state_q);
      tmrLoadVal = '0;
      case (state_d)
         S_WAIT_RD: tmrLoadVal = LD_RDTO;
         S_PULSE:   tmrLoadVal = LD_PUL;
         S_SETTLE:  tmrLoadVal = LD_SET;
         default:   tmrLoadVal = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         status_q     <= ST_OK;
         row_q        <= '0;
         col_q        <= '0;
         sign_q       <= 1'b0;
         target_q     <= '0;
         meas_q       <= '0;
         pulses_q     <= '0;
         respPulses_q <= '0;
         pol_q        <= POL_RESET;
         pulseEn_q    <= 1'b0;
         rdReq_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         status_q     <= status_d;
         row_q        <= row_d;
         col_q        <= col_d;
         sign_q       <= sign_d;
         target_q     <= target_d;
         meas_q       <= meas_d;
         pulses_q     <= pulses_d;
         respPulses_q <= respPulses_d;
         pol_q        <= pol_d;
         pulseEn_q    <= pulseEn_d;
         rdReq_q      <= rdReq_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_RESP);
   assign resp_status = status_q;
   assign resp_pulses = respPulses_q;
   assign sel_row     = row_q;
   assign sel_col     = col_q;
   assign wctl_sign   = sign_q;
   assign pulse_en    = pulseEn_q;
   assign pulse_pol   = pol_q;
   assign rd_req      = rdReq_q;

endmodule

// File: tb/tb_xbar_weight_programmer.sv
// Self-checking bench: two programmers (TOL=0 and TOL=1) driven against a
// behavioural memristor cell model, with table vectors plus abort/reset sequences.
module tb_xbar_weight_programmer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic [1:0] reqValid, reqReady, abortIn, wctlSign, pulseEn, pulsePol;
   logic [1:0] rdReq, rdValid, respValid, respReady;
   logic       reqSign;
   logic [5:0] reqRow, reqCol;
   logic [3:0] reqLevel;
   logic [5:0] selRow [2];
   logic [5:0] selCol [2];
   logic [3:0] rdLevel [2];
   logic [1:0] respStatus [2];
   logic [4:0] respPulses [2];

   int errors = 0;
   int checks = 0;

   xbar_weight_programmer #(.TOL(0)) u0 (
      .clk (clk), .rst_n (rst_n),
      .req_valid (reqValid[0]), .req_ready (reqReady[0]),
      .req_row (reqRow), .req_col (reqCol), .req_level (reqLevel), .req_sign (reqSign),
      .abort (abortIn[0]),
      .sel_row (selRow[0]), .sel_col (selCol[0]), .wctl_sign (wctlSign[0]),
      .pulse_en (pulseEn[0]), .pulse_pol (pulsePol[0]),
      .rd_req (rdReq[0]), .rd_valid (rdValid[0]), .rd_level (rdLevel[0]),
      .resp_valid (respValid[0]), .resp_ready (respReady[0]),
      .resp_status (respStatus[0]), .resp_pulses (respPulses[0])
   );

   xbar_weight_programmer #(.TOL(1)) u1 (
      .clk (clk), .rst_n (rst_n),
      .req_valid (reqValid[1]), .req_ready (reqReady[1]),
      .req_row (reqRow), .req_col (reqCol), .req_level (reqLevel), .req_sign (reqSign),
      .abort (abortIn[1]),
      .sel_row (selRow[1]), .sel_col (selCol[1]), .wctl_sign (wctlSign[1]),
      .pulse_en (pulseEn[1]), .pulse_pol (pulsePol[1]),
      .rd_req (rdReq[1]), .rd_valid (rdValid[1]), .rd_level (rdLevel[1]),
      .resp_valid (respValid[1]), .resp_ready (respReady[1]),
      .resp_status (respStatus[1]), .resp_pulses (respPulses[1])
   );

   // Cell model: answers a read strobe one cycle later, and moves the level by
   // one step in the pulse direction each time a pulse finishes.
   int  startLevel [2];
   bit  stuck [2];
   bit  respondEn [2];
   bit  modelClear;
   int  cellLevel [2];
   logic [1:0] prevPulse;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         rdValid[i]   <= rdReq[i] && respondEn[i];
         rdLevel[i]   <= 4'(cellLevel[i]);
         prevPulse[i] <= pulseEn[i];
         if (modelClear) begin
            cellLevel[i] <= startLevel[i];
         end else if (prevPulse[i] && !pulseEn[i] && !stuck[i]) begin
            if (pulsePol[i] && cellLevel[i] < 15) cellLevel[i] <= cellLevel[i] + 1;
            else if (!pulsePol[i] && cellLevel[i] > 0) cellLevel[i] <= cellLevel[i] - 1;
         end
      end
   end

   typedef struct {
      string name;
      int    dut;
      int    row;
      int    col;
      int    sign;
      int    target;
      int    start;
      bit    stuck;
      bit    respond;
      int    expStatus;
      int    expPulses;
      int    expLatency;
      int    expPol;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input int d, input string tag);
      checkOutput($sformatf("%s.d%0d.reqReady", tag, d), reqReady[d], 1);
      checkOutput($sformatf("%s.d%0d.pulseEn", tag, d), pulseEn[d], 0);
      checkOutput($sformatf("%s.d%0d.pulsePol", tag, d), pulsePol[d], 0);
      checkOutput($sformatf("%s.d%0d.rdReq", tag, d), rdReq[d], 0);
      checkOutput($sformatf("%s.d%0d.respValid", tag, d), respValid[d], 0);
      checkOutput($sformatf("%s.d%0d.respStatus", tag, d), respStatus[d], 0);
      checkOutput($sformatf("%s.d%0d.respPulses", tag, d), respPulses[d], 0);
      checkOutput($sformatf("%s.d%0d.selRow", tag, d), selRow[d], 0);
      checkOutput($sformatf("%s.d%0d.selCol", tag, d), selCol[d], 0);
      checkOutput($sformatf("%s.d%0d.wctlSign", tag, d), wctlSign[d], 0);
   endtask

   // Loads the cell model, then presents one request; returns just after the
   // accepting edge.
   task automatic issueRequest(input int d, input int row, input int col, input int sign,
                               input int target, input int start, input bit stk, input bit resp);
      startLevel[d] = start;
      stuck[d]      = stk;
      respondEn[d]  = resp;
      modelClear    = 1'b1;
      @(negedge clk);
      modelClear    = 1'b0;
      reqRow        = 6'(row);
      reqCol        = 6'(col);
      reqSign       = 1'(sign);
      reqLevel      = 4'(target);
      reqValid[d]   = 1'b1;
      checkOutput("reqReadyBeforeAccept", reqReady[d], 1);
      @(posedge clk);
      #1 reqValid[d] = 1'b0;
   endtask

   task automatic finishResp(input int d, input string tag);
      respReady[d] = 1'b1;
      @(posedge clk);
      #1 respReady[d] = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".reqReadyAfterResp"}, reqReady[d], 1);
      checkOutput({tag, ".respValidDropped"}, respValid[d], 0);
   endtask

   task automatic waitPulse(input int d, input logic lvl, input string tag);
      bit seen = 0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         if (pulseEn[d] === lvl) seen = 1;
      end
      checkOutput({tag, ".waitPulse"}, seen, 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      int d;
      int cycles;
      int run;
      int seenPulses;
      int minLen;
      int maxLen;
      bit polBad;
      bit done;
      logic firstPol;
      d = v.dut;
      cycles = 0; run = 0; seenPulses = 0; minLen = 1000; maxLen = 0;
      polBad = 0; done = 0; firstPol = 1'b0;
      issueRequest(d, v.row, v.col, v.sign, v.target, v.start, v.stuck, v.respond);
      while (!done && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) checkOutput({v.name, ".reqReadyBusy"}, reqReady[d], 0);
         if (pulseEn[d] === 1'b1) begin
            if (run == 0) firstPol = pulsePol[d];
            else if (pulsePol[d] !== firstPol) polBad = 1;
            if (v.expPol >= 0 && pulsePol[d] !== 1'(v.expPol)) polBad = 1;
            run++;
         end else if (run > 0) begin
            seenPulses++;
            if (run < minLen) minLen = run;
            if (run > maxLen) maxLen = run;
            run = 0;
         end
         if (respValid[d] === 1'b1) done = 1;
      end
      checkOutput({v.name, ".respSeen"}, done, 1);
      checkOutput({v.name, ".status"}, respStatus[d], v.expStatus);
      checkOutput({v.name, ".pulses"}, respPulses[d], v.expPulses);
      checkOutput({v.name, ".pulsesOnWire"}, seenPulses, v.expPulses);
      checkOutput({v.name, ".selRow"}, selRow[d], v.row);
      checkOutput({v.name, ".selCol"}, selCol[d], v.col);
      checkOutput({v.name, ".wctlSign"}, wctlSign[d], v.sign);
      if (v.expLatency >= 0) checkOutput({v.name, ".latency"}, cycles, v.expLatency);
      if (v.expPulses > 0) begin
         checkOutput({v.name, ".pulseLenMin"}, minLen, 8);
         checkOutput({v.name, ".pulseLenMax"}, maxLen, 8);
         checkOutput({v.name, ".polStable"}, polBad, 0);
      end
      @(negedge clk);
      checkOutput({v.name, ".respHeld"}, respValid[d], 1);
      checkOutput({v.name, ".statusHeld"}, respStatus[d], v.expStatus);
      finishResp(d, v.name);
   endtask

   initial begin
      vec_t vecs [8];
      vecs[0] = '{"match5",    0,  3, 60, 1,  5, 5, 1'b0, 1'b1, 0,  0,   4, -1};
      vecs[1] = '{"convUp",    0, 10, 20, 0,  7, 4, 1'b0, 1'b1, 0,  3,  49,  1};
      vecs[2] = '{"downTol1",  1, 63,  0, 1,  2, 9, 1'b0, 1'b1, 0,  6,  94,  0};
      vecs[3] = '{"budget",    0,  1,  2, 1, 15, 0, 1'b1, 1'b1, 1, 16, 244,  1};
      vecs[4] = '{"timeout",   0,  5,  5, 0,  8, 8, 1'b0, 1'b0, 2,  0,  34, -1};
      vecs[5] = '{"tol0Edge",  0, 33, 17, 1,  3, 4, 1'b0, 1'b1, 0,  1,  19,  0};
      vecs[6] = '{"tol1Edge",  1, 12, 44, 0,  3, 4, 1'b0, 1'b1, 0,  0,   4, -1};
      vecs[7] = '{"tol1Up",    1,  7,  9, 1,  9, 6, 1'b0, 1'b1, 0,  2,  34,  1};

      reqValid = '0; abortIn = '0; respReady = '0;
      reqRow = '0; reqCol = '0; reqLevel = '0; reqSign = 1'b0;
      modelClear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         startLevel[i] = 0; stuck[i] = 0; respondEn[i] = 1; cellLevel[i] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) checkResetState(d, "por");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Abort in the third cycle of the first pulse.
      issueRequest(0, 20, 21, 1, 10, 4, 1'b0, 1'b1);
      waitPulse(0, 1'b1, "abortPulse");
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortPulse.stillPulsing", pulseEn[0], 1);
      abortIn[0] = 1'b1;
      @(posedge clk);
      #1 abortIn[0] = 1'b0;
      @(negedge clk);
      checkOutput("abortPulse.pulseEnLow", pulseEn[0], 0);
      checkOutput("abortPulse.respValid", respValid[0], 1);
      checkOutput("abortPulse.status", respStatus[0], 3);
      checkOutput("abortPulse.pulses", respPulses[0], 1);
      finishResp(0, "abortPulse");

      // Abort arriving together with rd_valid in WAIT_RD must still abort.
      issueRequest(0, 22, 23, 0, 9, 2, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      abortIn[0] = 1'b1;
      @(posedge clk);
      #1 abortIn[0] = 1'b0;
      @(negedge clk);
      checkOutput("abortRead.respValid", respValid[0], 1);
      checkOutput("abortRead.status", respStatus[0], 3);
      checkOutput("abortRead.pulses", respPulses[0], 0);
      finishResp(0, "abortRead");

      // Abort in IDLE has no effect.
      abortIn[0] = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abortIdle.reqReady", reqReady[0], 1);
      checkOutput("abortIdle.respValid", respValid[0], 0);
      abortIn[0] = 1'b0;

      // Reset during SETTLE discards the request with no response.
      issueRequest(0, 40, 41, 1, 10, 4, 1'b0, 1'b1);
      waitPulse(0, 1'b1, "rstSettle");
      waitPulse(0, 1'b0, "rstSettle");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetState(0, "rstSettle");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstSettle.reqReadyAfter", reqReady[0], 1);
      begin
         bit sawResp = 0;
         repeat (20) begin
            @(negedge clk);
            if (respValid[0] !== 1'b0) sawResp = 1;
         end
         checkOutput("rstSettle.noResp", sawResp, 0);
      end

      // Reset during a pulse drops pulse_en without waiting for a clock edge.
      issueRequest(0, 50, 51, 1, 12, 3, 1'b0, 1'b1);
      waitPulse(0, 1'b1, "rstPulse");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstPulse.pulseEnAsync", pulseEn[0], 0);
      checkOutput("rstPulse.reqReady", reqReady[0], 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstPulse.reqReadyAfter", reqReady[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

endmodule
